// File: rtl/microcode_loader.sv
// Power-up sequencer that walks every control-unit EEPROM address {flags, opcode, step}
// and drives the matching control word, then hands the control unit over to run mode.
module microcode_loader #(
  parameter int MICROCODE_SIZE = 24,
  parameter int STEPS          = 16
) (
  input  logic                      clk,
  input  logic                      RESET,
  input  logic                      start,
  output logic [3:0]                ir_drive,
  output logic [1:0]                flags_drive,
  output logic                      RESET_counter,
  output logic                      eeprom_in,
  output logic                      eeprom_out,
  output logic [MICROCODE_SIZE-1:0] microcode,
  output logic [3:0]                step,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned B_HLT = 0;
  localparam int unsigned B_MI  = 1;
  localparam int unsigned B_RI  = 2;
  localparam int unsigned B_RO  = 3;
  localparam int unsigned B_IO  = 4;
  localparam int unsigned B_II  = 5;
  localparam int unsigned B_AI  = 6;
  localparam int unsigned B_AO  = 7;
  localparam int unsigned B_EO  = 8;
  localparam int unsigned B_SU  = 9;
  localparam int unsigned B_BI  = 10;
  localparam int unsigned B_OI  = 11;
  localparam int unsigned B_CE  = 12;
  localparam int unsigned B_CO  = 13;
  localparam int unsigned B_J   = 14;
  localparam int unsigned B_FI  = 15;

  localparam logic [3:0] LAST_STEP = 4'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_WRITE,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] g_q, g_d;
  logic [3:0] step_q, step_d;

  function automatic logic [MICROCODE_SIZE-1:0] table_word(
    input logic [1:0] f,
    input logic [3:0] op,
    input logic [3:0] s
  );
    logic [MICROCODE_SIZE-1:0] w;
    w = '0;
    case (s)
      4'd0: begin w[B_CO] = 1'b1; w[B_MI] = 1'b1; end
      4'd1: begin w[B_RO] = 1'b1; w[B_II] = 1'b1; w[B_CE] = 1'b1; end
      4'd2: begin
        case (op)
          4'b0001, 4'b0010: begin w[B_IO] = 1'b1; w[B_MI] = 1'b1; end
          4'b0110:          begin w[B_IO] = 1'b1; w[B_J]  = 1'b1; end
          // Conditional jumps bake the flag value into the word at this address.
          4'b0111:          begin w[B_IO] = f[0]; w[B_J]  = f[0]; end
          4'b1000:          begin w[B_IO] = f[1]; w[B_J]  = f[1]; end
          4'b1110:          begin w[B_AO] = 1'b1; w[B_OI] = 1'b1; end
          4'b1111:          w[B_HLT] = 1'b1;
          default:          ;
        endcase
      end
      4'd3: begin
        case (op)
          4'b0001: begin w[B_RO] = 1'b1; w[B_AI] = 1'b1; end
          4'b0010: begin w[B_RO] = 1'b1; w[B_BI] = 1'b1; end
          default: ;
        endcase
      end
      4'd4: begin
        if (op == 4'b0010) begin
          w[B_EO] = 1'b1; w[B_AI] = 1'b1; w[B_FI] = 1'b1;
        end
      end
      default: ;
    endcase
    w[B_SU] = 1'b0;
    w[B_RI] = 1'b0;
    return w;
  endfunction

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    g_d           = g_q;
    step_d        = step_q;
    ir_drive      = '0;
    flags_drive   = '0;
    RESET_counter = 1'b0;
    eeprom_in     = 1'b0;
    eeprom_out    = 1'b0;
    microcode     = '0;
    step          = '0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_q)
      S_IDLE: begin
        RESET_counter = 1'b1;
        if (start) begin
          state_d = S_CLR;
          g_d     = '0;
          step_d  = '0;
        end
      end
      S_CLR: begin
        RESET_counter = 1'b1;
        busy          = 1'b1;
        ir_drive      = g_q[3:0];
        flags_drive   = g_q[5:4];
        step_d        = '0;
        state_d       = S_WRITE;
      end
      S_WRITE: begin
        busy        = 1'b1;
        eeprom_in   = 1'b1;
        ir_drive    = g_q[3:0];
        flags_drive = g_q[5:4];
        step        = step_q;
        microcode   = table_word(g_q[5:4], g_q[3:0], step_q);
        if (step_q == LAST_STEP) begin
          step_d = '0;
          if (g_q == '1) begin
            state_d = S_DONE;
          end else begin
            g_d     = g_q + 6'd1;
            state_d = S_CLR;
          end
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        eeprom_out = 1'b1;
        if (start) begin
          state_d = S_CLR;
          g_d     = '0;
          step_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_microcode_loader.sv
// Scoreboard bench for microcode_loader: a spec-level table model queues every expected
// write; a negedge monitor pops and compares each write the DUT presents.
module tb_microcode_loader;

  logic        clk;
  logic        RESET;
  logic        start;
  logic [3:0]  ir_drive;
  logic [1:0]  flags_drive;
  logic        RESET_counter;
  logic        eeprom_in;
  logic        eeprom_out;
  logic [23:0] microcode;
  logic [3:0]  step;
  logic        busy;
  logic        done;

  microcode_loader #(.MICROCODE_SIZE(24), .STEPS(16)) dut (
    .clk(clk), .RESET(RESET), .start(start),
    .ir_drive(ir_drive), .flags_drive(flags_drive), .RESET_counter(RESET_counter),
    .eeprom_in(eeprom_in), .eeprom_out(eeprom_out), .microcode(microcode),
    .step(step), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [33:0] exp_q[$];
  int          cap_cnt[1024];
  logic [23:0] cap_word[1024];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Control words straight from the opcode table: fetch steps, then per-opcode steps.
  function automatic logic [23:0] ref_word(input int f, input int op, input int s);
    if (s == 0) return 24'h002002;
    if (s == 1) return 24'h001028;
    case (op)
      1:  return (s == 2) ? 24'h000012 : (s == 3) ? 24'h000048 : 24'h0;
      2:  return (s == 2) ? 24'h000012 : (s == 3) ? 24'h000408 :
                 (s == 4) ? 24'h008140 : 24'h0;
      6:  return (s == 2) ? 24'h004010 : 24'h0;
      7:  return (s == 2 && (f & 1) != 0) ? 24'h004010 : 24'h0;
      8:  return (s == 2 && (f & 2) != 0) ? 24'h004010 : 24'h0;
      14: return (s == 2) ? 24'h000880 : 24'h0;
      15: return (s == 2) ? 24'h000001 : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  function automatic int idx(input int f, input int op, input int s);
    return f * 256 + op * 16 + s;
  endfunction

  always @(negedge clk) begin
    if (!RESET) begin
      if (eeprom_in) begin
        logic [33:0] got;
        logic [33:0] exp;
        int          i;
        got = {flags_drive, ir_drive, step, microcode};
        i   = {22'd0, flags_drive, ir_drive, step};
        cap_cnt[i]++;
        cap_word[i] = microcode;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL write_unexpected: got 0x%0h expected no write", got);
        end else begin
          exp = exp_q.pop_front();
          check("write_seq", 64'(got), 64'(exp));
        end
      end else begin
        check("mc_zero_nonwrite", 64'(microcode), 64'd0);
      end
    end
  end

  task automatic do_start(output int s);
    for (int i = 0; i < 1024; i++) cap_cnt[i] = 0;
    exp_q.delete();
    for (int f = 0; f < 4; f++)
      for (int op = 0; op < 16; op++)
        for (int st = 0; st < 16; st++)
          exp_q.push_back({2'(f), 4'(op), 4'(st), ref_word(f, op, st)});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
    check("clr_busy", 64'(busy), 64'd1);
    check("clr_done", 64'(done), 64'd0);
    check("clr_eeprom_out", 64'(eeprom_out), 64'd0);
    check("clr_rst_cnt", 64'(RESET_counter), 64'd1);
    check("clr_eeprom_in", 64'(eeprom_in), 64'd0);
    check("clr_g", 64'({flags_drive, ir_drive}), 64'd0);
    @(negedge clk);
    check("w0_eeprom_in", 64'(eeprom_in), 64'd1);
    check("w0_step", 64'(step), 64'd0);
    check("w0_word", 64'(microcode), 64'h002002);
    check("w0_rst_cnt", 64'(RESET_counter), 64'd0);
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_done(input int s);
    int bad;
    for (int i = 0; i < 1200 && !done; i++) @(negedge clk);
    check("done_reached", 64'(done), 64'd1);
    check("load_cycles", 64'(cyc - s), 64'd1088);
    check("done_eeprom_out", 64'(eeprom_out), 64'd1);
    check("done_busy", 64'(busy), 64'd0);
    check("done_rst_cnt", 64'(RESET_counter), 64'd0);
    check("done_eeprom_in", 64'(eeprom_in), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (cap_cnt[i] != 1) bad++;
    check("write_once", 64'(bad), 64'd0);
  endtask

  task automatic check_entries();
    check("add_s4",   64'(cap_word[idx(0, 2, 4)]),  64'h008140);
    check("jc_c0",    64'(cap_word[idx(0, 7, 2)]),  64'h0);
    check("jc_c1",    64'(cap_word[idx(1, 7, 2)]),  64'h004010);
    check("jz_z1",    64'(cap_word[idx(2, 8, 2)]),  64'h004010);
    check("jz_z0",    64'(cap_word[idx(0, 8, 2)]),  64'h0);
    check("hlt_s2",   64'(cap_word[idx(3, 15, 2)]), 64'h000001);
  endtask

  initial begin
    int s;
    int tgt;
    RESET = 1'b0;
    start = 1'b0;
    @(negedge clk);
    #2 RESET = 1'b1;
    #1;
    check("rst_rst_cnt", 64'(RESET_counter), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_eeprom_in", 64'(eeprom_in), 64'd0);
    check("rst_eeprom_out", 64'(eeprom_out), 64'd0);
    check("rst_microcode", 64'(microcode), 64'd0);
    repeat (3) @(negedge clk);
    RESET = 1'b0;
    repeat ($urandom_range(1, 5)) @(negedge clk);
    check("idle_rst_cnt", 64'(RESET_counter), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);

    // Load 1 with a stray start during WRITE of g = 5.
    do_start(s);
    tgt = s + 5 * 17 + 1 + int'($urandom_range(0, 15));
    wait_cycle(tgt);
    check("stray_at_g5", 64'({flags_drive, ir_drive}), 64'd5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(s);
    check_entries();

    // Restart from DONE, then reset during g = 30.
    repeat ($urandom_range(1, 4)) @(negedge clk);
    do_start(s);
    tgt = s + 30 * 17 + 1 + int'($urandom_range(0, 15));
    wait_cycle(tgt);
    check("at_g30", 64'({flags_drive, ir_drive}), 64'd30);
    #2 RESET = 1'b1;
    #1;
    check("midrst_rst_cnt", 64'(RESET_counter), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_eeprom_in", 64'(eeprom_in), 64'd0);
    exp_q.delete();
    @(negedge clk);
    RESET = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_done", 64'(done), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_rst_cnt", 64'(RESET_counter), 64'd1);

    // Fresh full reload after the abandoned one.
    do_start(s);
    wait_done(s);
    check_entries();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/microcode_loader.md
Name: microcode_loader

Overview:
- Power-up sequencer directly upstream of the control unit.
- After `start`, walks every control-unit EEPROM address (flags[1:0], opcode[3:0], step[3:0]) and drives the matching 24-bit control word, so the three microcode EEPROMs are programmed from an internal table.
- On completion it hands the control unit over to run mode by enabling EEPROM outputs.
- Drives the control unit's IR_out, FLAGS_Register_out, RESET_counter, eeprom_in, eeprom_out and microcode inputs during load.

Parameters:
- MICROCODE_SIZE, 24, control-word width.
- STEPS, 16, microsteps per opcode; equals the control-unit step counter range.

Ports:
- clk  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin loading; ignored while busy.
- ir_drive  output  4  opcode presented to the control unit's IR_out.
- flags_drive  output  2  flags presented to FLAGS_Register_out; bit0 = C, bit1 = Z.
- RESET_counter  output  1  clears the control-unit step counter.
- eeprom_in  output  1  EEPROM write enable.
- eeprom_out  output  1  EEPROM output enable (run mode).
- microcode  output  MICROCODE_SIZE  control word to write.
- step  output  4  loader's mirror of the control-unit step counter.
- busy  output  1  high while loading.
- done  output  1  high after a complete load until the next start or reset.

Behaviour:
- Reset (asynchronous, immediate): state = IDLE.
  - RESET_counter = 1; all other outputs = 0.
- States: IDLE, CLR, WRITE, DONE.
- Group index g = {flags_drive, opcode} = 0..63. Flags are the major field, opcode the minor field; g increments by 1.
- IDLE:
  - RESET_counter = 1, eeprom_in = 0, eeprom_out = 0.
  - start → CLR with g = 0 and busy = 1.
- CLR (1 cycle):
  - RESET_counter = 1, eeprom_in = 0, step = 0.
  - Next state: WRITE.
- WRITE (STEPS cycles):
  - RESET_counter = 0, eeprom_in = 1, microcode = TABLE(flags_drive, ir_drive, step).
  - step increments each cycle, in lockstep with the control-unit counter.
  - At step = STEPS-1: if g = 63 go to DONE, else increment g and go to CLR.
- DONE:
  - busy = 0, done = 1, eeprom_in = 0, eeprom_out = 1, RESET_counter = 0, microcode = 0.
  - start → CLR with g = 0, done = 0, eeprom_out = 0.
- Full load takes 64 × (1 + STEPS) = 1088 cycles from the start edge to DONE.
- start while busy: ignored. Reset mid-load: back to IDLE, partial load is abandoned, done = 0.
- microcode = 0 in every state except WRITE.
- Bit map:
  - 0 HLT, 1 MI, 2 RI, 3 RO, 4 IO, 5 II, 6 AI, 7 AO, 8 EO, 9 SU, 10 BI, 11 OI, 12 CE, 13 CO, 14 J, 15 FI.
  - Bits 23:16 = 0.
- TABLE, all opcodes:
  - step 0 = CO|MI (0x2002).
  - step 1 = RO|II|CE (0x1028).
  - Unlisted steps = 0.
- TABLE, per opcode (steps 2 onward):
  - 0001 LDA: step 2 = IO|MI (0x0012), step 3 = RO|AI (0x0048).
  - 0010 ADD: step 2 = 0x0012, step 3 = RO|BI (0x0408), step 4 = EO|AI|FI (0x8140).
  - 0110 JMP: step 2 = IO|J (0x4010).
  - 0111 JC: step 2 = 0x4010 if flags_drive[0], else 0.
  - 1000 JZ: step 2 = 0x4010 if flags_drive[1], else 0.
  - 1110 OUT: step 2 = AO|OI (0x0880).
  - 1111 HLT: step 2 = HLT (0x0001).
  - All other opcodes: fetch steps only.
- Flags affect only JC and JZ.

Test Plan:
- Reset asserted asynchronously mid-cycle → RESET_counter = 1 and busy = done = eeprom_in = eeprom_out = 0 with no clock edge; IDLE held.
- start pulse → next cycle CLR with ir_drive = 0, flags_drive = 0; following cycle eeprom_in = 1, step = 0, microcode = 0x002002. done rises exactly 1088 cycles after the start edge, with eeprom_out = 1.
- Capture all writes in a 1024-entry model indexed {flags, opcode, step}:
  - {00, 0010, 4} = 0x008140.
  - {00, 0111, 2} = 0; {01, 0111, 2} = 0x004010.
  - {10, 1000, 2} = 0x004010; {00, 1000, 2} = 0.
  - {11, 1111, 2} = 0x000001.
  - Every entry written exactly once.
- Second start pulse during WRITE of g = 5 → ignored; sequence and final cycle count unchanged.
- RESET pulse at g = 30 → IDLE, done stays 0. New start reloads from g = 0 and completes in 1088 cycles.
- Restart from DONE → done and eeprom_out drop on the start edge, then the full 1088-cycle reload runs.
